module_control_fsm_multicycle_v2: RTL and testbench

MODULE_CONTROL_FSM_MULTICYCLE_V2 -- requirements
Module: module_control_fsm_multicycle_v2

---
 rtl/pkg_multicycle_ctrl.sv | 53 +++++
 rtl/module_instret_counter.sv | 19 +
 rtl/module_control_fsm_multicycle_v2.sv | 172 +++++++++++++++++
 tb/tb_module_control_fsm_multicycle_v2.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_multicycle_ctrl.sv
// Shared types and encodings for the multicycle RISC-V control FSM.
package pkg_multicycle_ctrl;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 7;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_BRANCH   = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;
    localparam logic [SEL_W-1:0] SRCA_ZERO  = 2'b11;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALU_FUNCT = 2'b10;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/module_instret_counter.sv
// Retired-instruction counter; wraps modulo 2^CNT_W.
module module_instret_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/module_control_fsm_multicycle_v2.sv
// Multicycle RISC-V main controller: Moore FSM driving datapath selects/enables
// plus a retired-instruction counter.
module module_control_fsm_multicycle_v2
    import pkg_multicycle_ctrl::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter bit          MEM_HS_EN = 1'b1,
    parameter bit          UTYPE_EN  = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             adrsrc_o,
    output logic             memwrite_o,
    output logic             irwrite_o,
    output logic             regwrite_o,
    output logic             branch_o,
    output logic             pcupdate_o,
    output logic [SEL_W-1:0] resultsrc_o,
    output logic [SEL_W-1:0] alusrca_o,
    output logic [SEL_W-1:0] alusrcb_o,
    output logic [SEL_W-1:0] aluop_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instret_o
);

    state_t state_q;
    state_t state_d;
    logic   mem_rdy;
    logic   retire_c;

    assign mem_rdy = MEM_HS_EN ? mem_ready_i : 1'b1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; TRAP is absorbing until reset.
    always_comb begin
        state_d = S_TRAP;
        case (state_q)
            S_FETCH:    state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_i)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = S_EXECUTER;
                    OP_ITYPE:  state_d = S_EXECUTEI;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_LUI:    state_d = UTYPE_EN ? S_LUI : S_TRAP;
                    OP_AUIPC:  state_d = UTYPE_EN ? S_AUIPC : S_TRAP;
                    default:   state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op_i == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_rdy ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JAL;
            S_BRANCH:   state_d = S_FETCH;
            S_LUI:      state_d = S_ALUWB;
            S_AUIPC:    state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    // Moore output decode; only FETCH's IR/PC enables follow mem ready.
    always_comb begin
        mem_req_o   = 1'b0;
        adrsrc_o    = 1'b0;
        memwrite_o  = 1'b0;
        irwrite_o   = 1'b0;
        regwrite_o  = 1'b0;
        branch_o    = 1'b0;
        pcupdate_o  = 1'b0;
        resultsrc_o = RES_ALUOUT;
        alusrca_o   = SRCA_PC;
        alusrcb_o   = SRCB_RS2;
        aluop_o     = ALU_ADD;
        illegal_o   = 1'b0;
        retire_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_o   = 1'b1;
                alusrcb_o   = SRCB_FOUR;
                resultsrc_o = RES_ALURES;
                irwrite_o   = mem_rdy;
                pcupdate_o  = mem_rdy;
            end
            S_DECODE: begin
                alusrca_o = SRCA_OLDPC;
                alusrcb_o = SRCB_IMM;
            end
            S_MEMADR, S_JALR: begin
                alusrca_o = SRCA_RS1;
                alusrcb_o = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req_o = 1'b1;
                adrsrc_o  = 1'b1;
            end
            S_MEMWB: begin
                resultsrc_o = RES_DATA;
                regwrite_o  = 1'b1;
                retire_c    = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_o  = 1'b1;
                adrsrc_o   = 1'b1;
                memwrite_o = 1'b1;
                retire_c   = mem_rdy;
            end
            S_EXECUTER: begin
                alusrca_o = SRCA_RS1;
                aluop_o   = ALU_FUNCT;
            end
            S_EXECUTEI: begin
                alusrca_o = SRCA_RS1;
                alusrcb_o = SRCB_IMM;
                aluop_o   = ALU_FUNCT;
            end
            S_ALUWB: begin
                regwrite_o = 1'b1;
                retire_c   = 1'b1;
            end
            S_JAL: begin
                alusrca_o  = SRCA_OLDPC;
                alusrcb_o  = SRCB_FOUR;
                pcupdate_o = 1'b1;
            end
            S_BRANCH: begin
                alusrca_o = SRCA_RS1;
                aluop_o   = ALU_SUB;
                branch_o  = 1'b1;
                retire_c  = 1'b1;
            end
            S_LUI: begin
                alusrca_o = SRCA_ZERO;
                alusrcb_o = SRCB_IMM;
            end
            S_AUIPC: begin
                alusrca_o = SRCA_OLDPC;
                alusrcb_o = SRCB_IMM;
            end
            S_TRAP:  illegal_o = 1'b1;
            default: ;
        endcase
    end

    module_instret_counter #(
        .CNT_W (CNT_W)
    ) u_instret (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (retire_c),
        .count (instret_o)
    );

endmodule

// File: tb/tb_module_control_fsm_multicycle_v2.sv
// Table-driven, scoreboarded bench for the multicycle control FSM.
module tb_module_control_fsm_multicycle_v2;

    typedef struct {
        logic [6:0]  op;
        logic        rdy;
        logic [15:0] exp;
        logic        ret;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        logic [31:0] cnt;
    } sb_t;

    // {mem_req, adrsrc, memwrite, irwrite, regwrite, branch, pcupdate,
    //  resultsrc[2], alusrca[2], alusrcb[2], aluop[2], illegal}
    localparam logic [15:0] E_F1   = {7'b1001001, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [15:0] E_F0   = {7'b1000000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [15:0] E_DEC  = {7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
    localparam logic [15:0] E_MADR = {7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
    localparam logic [15:0] E_MRD  = {7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_MWB  = {7'b0000100, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_MWR  = {7'b1110000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_EXR  = {7'b0000000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
    localparam logic [15:0] E_EXI  = {7'b0000000, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
    localparam logic [15:0] E_AWB  = {7'b0000100, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_JAL  = {7'b0000001, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
    localparam logic [15:0] E_JALR = {7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
    localparam logic [15:0] E_BR   = {7'b0000010, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
    localparam logic [15:0] E_LUI  = {7'b0000000, 2'b00, 2'b11, 2'b01, 2'b00, 1'b0};
    localparam logic [15:0] E_AUI  = {7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
    localparam logic [15:0] E_TRAP = 16'h0001;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, ADD = 7'b0110011,
                           ADDI = 7'b0010011, JAL = 7'b1101111, JALR = 7'b1100111,
                           BEQ = 7'b1100011, LUI = 7'b0110111, AUIPC = 7'b0010111,
                           BAD = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op;
    logic        rdy;

    logic        mem_req, adrsrc, memwrite, irwrite, regwrite, branch, pcupdate, illegal;
    logic [1:0]  resultsrc, alusrca, alusrcb, aluop;
    logic [31:0] instret;
    logic [15:0] obs;

    logic        x_mem_req, x_adrsrc, x_memwrite, x_irwrite, x_regwrite, x_branch;
    logic        x_pcupdate, x_illegal;
    logic [1:0]  x_resultsrc, x_alusrca, x_alusrcb, x_aluop;
    logic [7:0]  x_instret;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = '0;
    vec_t        vecs[$];
    sb_t         sb[$];

    always #5 clk = ~clk;

    assign obs = {mem_req, adrsrc, memwrite, irwrite, regwrite, branch, pcupdate,
                  resultsrc, alusrca, alusrcb, aluop, illegal};

    module_control_fsm_multicycle_v2 dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .op_i        (op),
        .mem_ready_i (rdy),
        .mem_req_o   (mem_req),
        .adrsrc_o    (adrsrc),
        .memwrite_o  (memwrite),
        .irwrite_o   (irwrite),
        .regwrite_o  (regwrite),
        .branch_o    (branch),
        .pcupdate_o  (pcupdate),
        .resultsrc_o (resultsrc),
        .alusrca_o   (alusrca),
        .alusrcb_o   (alusrcb),
        .aluop_o     (aluop),
        .illegal_o   (illegal),
        .instret_o   (instret)
    );

    // 8-bit counter, no memory handshake, no U-type instructions.
    module_control_fsm_multicycle_v2 #(
        .CNT_W     (8),
        .MEM_HS_EN (1'b0),
        .UTYPE_EN  (1'b0)
    ) dutx (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .op_i        (op),
        .mem_ready_i (rdy),
        .mem_req_o   (x_mem_req),
        .adrsrc_o    (x_adrsrc),
        .memwrite_o  (x_memwrite),
        .irwrite_o   (x_irwrite),
        .regwrite_o  (x_regwrite),
        .branch_o    (x_branch),
        .pcupdate_o  (x_pcupdate),
        .resultsrc_o (x_resultsrc),
        .alusrca_o   (x_alusrca),
        .alusrcb_o   (x_alusrcb),
        .aluop_o     (x_aluop),
        .illegal_o   (x_illegal),
        .instret_o   (x_instret)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add_v(input logic [6:0] o, input logic r, input logic [15:0] e,
                         input logic ret);
        vecs.push_back('{op: o, rdy: r, exp: e, ret: ret});
    endtask

    // Drive one low phase, score it, then move to the next low phase.
    task automatic apply(input vec_t v, input string tag);
        sb_t s;
        op  = v.op;
        rdy = v.rdy;
        sb.push_back('{out: v.exp, cnt: exp_cnt});
        if (v.ret) exp_cnt = exp_cnt + 32'd1;
        #2;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            s = sb.pop_front();
            chk({tag, "_out"}, 64'(obs), 64'(s.out));
            chk({tag, "_cnt"}, 64'(instret), 64'(s.cnt));
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        op    = ADD;
        rdy   = 1'b0;

        add_v(ADD, 1, E_F1, 0);  add_v(ADD, 1, E_DEC, 0);
        add_v(ADD, 1, E_EXR, 0); add_v(ADD, 1, E_AWB, 1);
        add_v(LW, 1, E_F1, 0);   add_v(LW, 1, E_DEC, 0);  add_v(LW, 1, E_MADR, 0);
        add_v(LW, 0, E_MRD, 0);  add_v(LW, 0, E_MRD, 0);  add_v(LW, 0, E_MRD, 0);
        add_v(LW, 1, E_MRD, 0);  add_v(LW, 1, E_MWB, 1);
        add_v(SW, 1, E_F1, 0);   add_v(SW, 1, E_DEC, 0);  add_v(SW, 1, E_MADR, 0);
        add_v(SW, 1, E_MWR, 1);
        add_v(SW, 1, E_F1, 0);   add_v(SW, 1, E_DEC, 0);  add_v(SW, 1, E_MADR, 0);
        add_v(SW, 0, E_MWR, 0);  add_v(SW, 1, E_MWR, 1);
        add_v(BEQ, 1, E_F1, 0);  add_v(BEQ, 1, E_DEC, 0); add_v(BEQ, 1, E_BR, 1);
        add_v(ADDI, 1, E_F1, 0); add_v(ADDI, 1, E_DEC, 0);
        add_v(ADDI, 1, E_EXI, 0); add_v(ADDI, 1, E_AWB, 1);
        add_v(JAL, 1, E_F1, 0);  add_v(JAL, 1, E_DEC, 0);
        add_v(JAL, 1, E_JAL, 0); add_v(JAL, 1, E_AWB, 1);
        add_v(JALR, 1, E_F1, 0); add_v(JALR, 1, E_DEC, 0); add_v(JALR, 1, E_JALR, 0);
        add_v(JALR, 1, E_JAL, 0); add_v(JALR, 1, E_AWB, 1);
        add_v(LUI, 1, E_F1, 0);  add_v(LUI, 1, E_DEC, 0);
        add_v(LUI, 1, E_LUI, 0); add_v(LUI, 1, E_AWB, 1);
        add_v(AUIPC, 1, E_F1, 0); add_v(AUIPC, 1, E_DEC, 0);
        add_v(AUIPC, 1, E_AUI, 0); add_v(AUIPC, 1, E_AWB, 1);
        add_v(ADD, 0, E_F0, 0);  add_v(ADD, 0, E_F0, 0);  add_v(ADD, 1, E_F1, 0);
        add_v(ADD, 1, E_DEC, 0); add_v(ADD, 1, E_EXR, 0); add_v(ADD, 1, E_AWB, 1);
        add_v(BAD, 1, E_F1, 0);  add_v(BAD, 1, E_DEC, 0);
        for (int i = 0; i < 10; i++) add_v(BAD, 1'(i % 2), E_TRAP, 0);

        // Reset state, including the no-handshake variant ignoring ready.
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out", 64'(obs), 64'(E_F0));
        chk("reset_cnt", 64'(instret), 64'd0);
        chk("reset_nohs_irwrite", 64'(x_irwrite), 64'd1);
        chk("reset_x_illegal", 64'(x_illegal), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset out of TRAP, no clock edge needed.
        rst_n = 1'b0;
        rdy   = 1'b1;
        #1;
        chk("trap_reset_out", 64'(obs), 64'(E_F1));
        chk("trap_reset_cnt", 64'(instret), 64'd0);
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a MEMREAD wait.
        apply('{op: LW, rdy: 1, exp: E_F1, ret: 0}, "w_f");
        apply('{op: LW, rdy: 1, exp: E_DEC, ret: 0}, "w_d");
        apply('{op: LW, rdy: 1, exp: E_MADR, ret: 0}, "w_a");
        apply('{op: LW, rdy: 0, exp: E_MRD, ret: 0}, "w_r");
        rst_n = 1'b0;
        #1;
        chk("wait_reset_out", 64'(obs), 64'(E_F0));
        @(negedge clk);
        rst_n = 1'b1;

        // 256 back-to-back adds: 8-bit counter wraps.
        op  = ADD;
        rdy = 1'b1;
        repeat (1020) @(negedge clk);
        chk("wrap_255_x", 64'(x_instret), 64'hff);
        chk("wrap_255", 64'(instret), 64'd255);
        repeat (4) @(negedge clk);
        chk("wrap_0_x", 64'(x_instret), 64'd0);
        chk("wrap_256", 64'(instret), 64'd256);

        // LUI traps only when U-type is disabled.
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        apply('{op: LUI, rdy: 1, exp: E_F1, ret: 0}, "u_f");
        apply('{op: LUI, rdy: 1, exp: E_DEC, ret: 0}, "u_d");
        #1;
        chk("utype_off_trap", 64'(x_illegal), 64'd1);
        chk("utype_on_legal", 64'(illegal), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
